// File: rtl/led_pkg.sv
// Shared definitions for the LED sequencer: mode encodings, pattern width, default timing.
// Other board blocks import it so they use the same mode numbering.
package led_pkg;
  localparam int PAT_W        = 4;
  localparam int STEP_DIV_DEF = 6_250_000;
  localparam int DEBOUNCE_DEF = 250_000;

  typedef enum logic [1:0] {
    BLINK  = 2'd0,
    CHASE  = 2'd1,
    BOUNCE = 2'd2,
    BINARY = 2'd3
  } mode_t;

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      BLINK:   return CHASE;
      CHASE:   return BOUNCE;
      BOUNCE:  return BINARY;
      default: return BLINK;
    endcase
  endfunction

  function automatic logic [PAT_W-1:0] init_pattern(input mode_t m);
    case (m)
      CHASE, BOUNCE: return 4'b0001;
      default:       return 4'b0000;
    endcase
  endfunction
endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchronizer plus debouncer. The level and the press pulse are registered;
// the press pulse lines up with the cycle the level first reads 1. No backpressure.
module switch_debounce
  import led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  output logic o_Level,
  output logic o_Press
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync_1;
  logic          sync_2;
  logic [DW-1:0] count;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync_1  <= 1'b0;
      sync_2  <= 1'b0;
      o_Level <= 1'b0;
      o_Press <= 1'b0;
      count   <= '0;
    end else begin
      sync_1  <= i_Switch;
      sync_2  <= sync_1;
      o_Press <= 1'b0;
      // Any cycle that matches the accepted level restarts the stability window.
      if (sync_2 == o_Level) begin
        count <= '0;
      end else if (count == DW'(DEBOUNCE_CYCLES - 1)) begin
        count   <= '0;
        o_Level <= sync_2;
        o_Press <= sync_2;
      end else begin
        count <= count + 1'b1;
      end
    end
  end
endmodule

// File: rtl/led_sequencer.sv
// Four-mode LED pattern generator that steps once per prescaler tick and advances mode on each button press.
// Pattern changes reach the LEDs one cycle after the tick or press; a press wins over a coincident tick.
module led_sequencer
  import led_pkg::*;
#(
  parameter int STEP_DIV        = STEP_DIV_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Switch_1,
  output logic       o_LED_1,
  output logic       o_LED_2,
  output logic       o_LED_3,
  output logic       o_LED_4,
  output logic [1:0] o_Mode
);
  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  logic             press;
  logic             level_unused;
  logic [CW-1:0]    presc;
  logic             tick;
  mode_t            mode;
  logic [PAT_W-1:0] pattern;
  logic             dir_up;
  logic [PAT_W-1:0] bounce_next;

  switch_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_switch_debounce (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Switch(i_Switch_1),
    .o_Level (level_unused),
    .o_Press (press)
  );

  assign tick = (presc == CW'(STEP_DIV - 1));

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      presc <= '0;
    end else if (press || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_comb begin
    bounce_next = dir_up ? {pattern[PAT_W-2:0], 1'b0} : {1'b0, pattern[PAT_W-1:1]};
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      mode    <= BLINK;
      pattern <= '0;
      dir_up  <= 1'b1;
    end else if (press) begin
      mode    <= next_mode(mode);
      pattern <= init_pattern(next_mode(mode));
      dir_up  <= 1'b1;
    end else if (tick) begin
      case (mode)
        BLINK:  pattern <= ~pattern;
        CHASE:  pattern <= {pattern[PAT_W-2:0], pattern[PAT_W-1]};
        BOUNCE: begin
          pattern <= bounce_next;
          // Reverse as the end position is reached so the next step heads back.
          if (bounce_next == 4'b1000) begin
            dir_up <= 1'b0;
          end else if (bounce_next == 4'b0001) begin
            dir_up <= 1'b1;
          end
        end
        default: pattern <= pattern + 1'b1;
      endcase
    end
  end

  assign o_LED_1 = pattern[0];
  assign o_LED_2 = pattern[1];
  assign o_LED_3 = pattern[2];
  assign o_LED_4 = pattern[3];
  assign o_Mode  = mode;
endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with STEP_DIV=4 and DEBOUNCE_CYCLES=8.
module tb_led_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       sw;
  logic       led_1, led_2, led_3, led_4;
  logic [1:0] mode;
  logic [3:0] leds;
  int         n_checks = 0;
  int         n_pass = 0;

  led_sequencer #(
    .STEP_DIV       (4),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .i_Clk     (clk),
    .i_Rst_L   (rst_n),
    .i_Switch_1(sw),
    .o_LED_1   (led_1),
    .o_LED_2   (led_2),
    .o_LED_3   (led_3),
    .o_LED_4   (led_4),
    .o_Mode    (mode)
  );

  assign leds = {led_4, led_3, led_2, led_1};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Switch rises one step after edge E; the press is accepted at edge E+11.
  task automatic press(input logic [1:0] m_old, input logic [1:0] m_new, input logic [3:0] p_init);
    sw = 1'b1;
    step(10);
    check("pre_press_mode", 8'(mode), 8'(m_old));
    step(1);
    check("press_mode", 8'(mode), 8'(m_new));
    check("press_init", 8'(leds), 8'(p_init));
    step(1);
    sw = 1'b0;
  endtask

  logic [3:0] bounce_exp [8];

  initial begin
    bounce_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100};
    rst_n = 1'b0;
    sw    = 1'b0;
    step(2);
    check("reset_leds", 8'(leds), 8'h0);
    check("reset_mode", 8'(mode), 8'h0);
    rst_n = 1'b1;

    // BLINK free-run: tick every 4 cycles.
    step(3);
    check("blink_e3", 8'(leds), 8'b0000);
    step(1);
    check("blink_tick1", 8'(leds), 8'b1111);
    step(3);
    check("blink_e7", 8'(leds), 8'b1111);
    step(1);
    check("blink_tick2", 8'(leds), 8'b0000);
    step(4);
    check("blink_tick3", 8'(leds), 8'b1111);
    step(4);
    check("blink_tick4", 8'(leds), 8'b0000);
    step(4);
    check("blink_tick5", 8'(leds), 8'b1111);
    check("blink_mode", 8'(mode), 8'h0);

    // CHASE via a 12-cycle press.
    press(2'd0, 2'd1, 4'b0001);
    step(3);
    check("chase_1", 8'(leds), 8'b0010);
    step(4);
    check("chase_2", 8'(leds), 8'b0100);
    step(4);
    check("chase_3", 8'(leds), 8'b1000);
    step(4);
    check("chase_wrap", 8'(leds), 8'b0001);

    // Glitchy switch must not change mode.
    sw = 1'b1; step(5);
    sw = 1'b0; step(1);
    sw = 1'b1; step(5);
    sw = 1'b0; step(20);
    check("glitch_mode", 8'(mode), 8'h1);
    check("glitch_leds", 8'(leds), 8'b1000);

    // BOUNCE.
    press(2'd1, 2'd2, 4'b0001);
    for (int i = 0; i < 8; i++) begin
      step(i == 0 ? 3 : 4);
      check($sformatf("bounce_%0d", i), 8'(leds), 8'(bounce_exp[i]));
    end

    // BINARY: 17 ticks.
    press(2'd2, 2'd3, 4'b0000);
    for (int i = 0; i < 17; i++) begin
      logic [3:0] e;
      e = 4'(i + 1);
      step(i == 0 ? 3 : 4);
      check($sformatf("binary_%0d", i), 8'(leds), 8'(e));
    end

    // Press accepted on the same edge as a tick: press wins, tick lost.
    step(1);
    sw = 1'b1;
    step(10);
    check("align_pre_mode", 8'(mode), 8'h3);
    check("align_pre_leds", 8'(leds), 8'b0011);
    step(1);
    check("align_mode", 8'(mode), 8'h0);
    check("align_leds", 8'(leds), 8'b0000);
    step(1);
    sw = 1'b0;
    step(2);
    check("align_no_tick", 8'(leds), 8'b0000);
    step(1);
    check("align_next_tick", 8'(leds), 8'b1111);

    // Async reset in CHASE with switch held high.
    step(12);
    press(2'd0, 2'd1, 4'b0001);
    sw = 1'b1;
    step(5);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_leds", 8'(leds), 8'h0);
    check("arst_mode", 8'(mode), 8'h0);
    step(2);
    rst_n = 1'b1;
    step(10);
    check("post_rst_mode_e10", 8'(mode), 8'h0);
    step(1);
    check("post_rst_mode_e11", 8'(mode), 8'h1);
    check("post_rst_leds", 8'(leds), 8'b0001);
    sw = 1'b0;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
